// File: rtl/fpu_add_issue_ctrl_if.sv
// Bundle of requester, adder and response signals around the shared FP adder issue controller.
// The slave view belongs to the controller; the master view belongs to its surroundings.
interface fpu_add_issue_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req0_sub;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              req1_sub;
    logic              add_issue;
    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;
    logic              add_sub;
    logic [DATA_W-1:0] add_result;
    logic [2:0]        add_flags;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic [2:0]        rsp_flags;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sub,
        output req1_ready,
        output add_issue, add_a, add_b, add_sub,
        input  add_result, add_flags,
        output rsp_valid, rsp_id, rsp_result, rsp_flags,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sub,
        input  req1_ready,
        input  add_issue, add_a, add_b, add_sub,
        output add_result, add_flags,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags,
        output rsp_ready
    );
endinterface

// File: rtl/fpu_add_issue_ctrl.sv
// Shares one fixed-latency FP adder between two requesters; results return in issue order
// through a response FIFO, with credit-based admission so nothing is ever dropped.
module fpu_add_issue_ctrl #(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned RSP_DEPTH = 8,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    fpu_add_issue_ctrl_if.slave   bus,
    output logic                  busy
);
    localparam int unsigned OCC_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned ENT_W = DATA_W + 4;

    logic [OCC_W-1:0]   occ;
    logic               rr_ptr;
    logic               credit_ok;
    logic               grant0;
    logic               grant1;
    logic               acc0;
    logic               acc1;
    logic               accept;
    logic               pop;
    logic               push;
    logic               issue_id;
    logic [LATENCY-1:0] tag_v;
    logic [LATENCY-1:0] tag_id;
    logic [ENT_W-1:0]   mem [RSP_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   fifo_cnt;
    logic [ENT_W-1:0]   head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit comes only from the registered occupancy; a same-cycle pop does not count.
    assign credit_ok = occ < OCC_W'(RSP_DEPTH);

    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | ~rr_ptr);
        grant1 = bus.req1_valid & (~bus.req0_valid |  rr_ptr);
    end

    assign bus.req0_ready = grant0 & credit_ok;
    assign bus.req1_ready = grant1 & credit_ok;
    assign acc0   = bus.req0_valid & bus.req0_ready;
    assign acc1   = bus.req1_valid & bus.req1_ready;
    assign accept = acc0 | acc1;
    assign pop    = bus.rsp_valid & bus.rsp_ready;
    assign push   = tag_v[LATENCY-1];
    assign busy   = (occ != '0);

    // Outstanding-operation count and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ    <= '0;
            rr_ptr <= 1'b0;
        end else begin
            case ({accept, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (accept) rr_ptr <= acc0;
        end
    end

    // Issue register: operands held when nothing is launched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.add_issue <= 1'b0;
            bus.add_a     <= '0;
            bus.add_b     <= '0;
            bus.add_sub   <= 1'b0;
            issue_id      <= 1'b0;
        end else begin
            bus.add_issue <= accept;
            if (accept) begin
                bus.add_a   <= acc1 ? bus.req1_a   : bus.req0_a;
                bus.add_b   <= acc1 ? bus.req1_b   : bus.req0_b;
                bus.add_sub <= acc1 ? bus.req1_sub : bus.req0_sub;
                issue_id    <= acc1;
            end
        end
    end

    // Tag pipe follows add_issue so its last stage lines up with add_result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= bus.add_issue;
            tag_id[0] <= issue_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // Response FIFO, first-word-fall-through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {tag_id[LATENCY-1], bus.add_flags, bus.add_result};
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + OCC_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - OCC_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign head           = mem[rd_ptr];
    assign bus.rsp_valid  = (fifo_cnt != '0);
    assign bus.rsp_id     = head[ENT_W-1];
    assign bus.rsp_flags  = head[DATA_W+2:DATA_W];
    assign bus.rsp_result = head[DATA_W-1:0];
endmodule

// File: tb/tb_fpu_add_issue_ctrl.sv
// Directed bench for the shared FP adder issue controller, with a behavioural fixed-latency adder.
module tb_fpu_add_issue_ctrl;
    localparam int unsigned LATENCY   = 4;
    localparam int unsigned RSP_DEPTH = 8;
    localparam int unsigned DATA_W    = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    fpu_add_issue_ctrl_if #(.DATA_W(DATA_W)) bus ();

    fpu_add_issue_ctrl #(
        .LATENCY(LATENCY), .RSP_DEPTH(RSP_DEPTH), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stand-in adder: two real FP cases, everything else plain integer math for unique tags.
    function automatic logic [34:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !sub) return {3'b000, 32'h4040_0000};
        if (a == 32'h7F00_0000 && b == 32'h7F00_0000 && !sub) return {3'b100, 32'h7F80_0000};
        return {3'b000, sub ? (a - b) : (a + b)};
    endfunction

    logic [34:0] pipe [LATENCY];
    always @(posedge clk) begin
        pipe[0] <= bus.add_issue ? fp_model(bus.add_a, bus.add_b, bus.add_sub) : 35'h0;
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.add_result = pipe[LATENCY-1][31:0];
    assign bus.add_flags  = pipe[LATENCY-1][34:32];

    // Monitor samples pre-edge values at each rising edge.
    int          acc0_cnt = 0;
    int          acc1_cnt = 0;
    logic        got_id  [$];
    logic [31:0] got_res [$];
    logic [2:0]  got_flg [$];
    always @(posedge clk) begin
        if (rst) begin
            if (bus.req0_valid && bus.req0_ready) acc0_cnt++;
            if (bus.req1_valid && bus.req1_ready) acc1_cnt++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                got_id.push_back(bus.rsp_id);
                got_res.push_back(bus.rsp_result);
                got_flg.push_back(bus.rsp_flags);
            end
            check("no_push_when_full",
                  64'(dut.tag_v[LATENCY-1] && (dut.fifo_cnt == 4'(RSP_DEPTH))
                      && !(bus.rsp_valid && bus.rsp_ready)), 64'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_rsp(input int target, input string tag);
        int budget = 40;
        while (got_res.size() < target && budget > 0) begin
            tick();
            budget--;
        end
        check(tag, 64'(got_res.size()), 64'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int gb;
        int ab;
        logic        e_id  [4];
        logic [31:0] e_res [4];

        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 0;
        bus.rsp_ready  = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_add_issue",  bus.add_issue,  0);
        check("rst_add_a",      bus.add_a,      0);
        check("rst_rsp_valid",  bus.rsp_valid,  0);
        check("rst_rsp_result", bus.rsp_result, 0);
        check("rst_busy",       busy,           0);
        tick();
        rst = 1'b1;

        // 1: single op latency, 1.0 + 2.0
        repeat (5) tick();
        bus.rsp_ready = 1;
        bus.req0_valid = 1; bus.req0_a = 32'h3F80_0000; bus.req0_b = 32'h4000_0000; bus.req0_sub = 0;
        @(negedge clk);
        check("t1_req0_ready", bus.req0_ready, 1);
        check("t1_req1_ready", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 0;
        @(negedge clk);
        check("t1_add_issue", bus.add_issue, 1);
        check("t1_add_a",     bus.add_a,     32'h3F80_0000);
        check("t1_add_b",     bus.add_b,     32'h4000_0000);
        check("t1_add_sub",   bus.add_sub,   0);
        check("t1_busy",      busy,          1);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check("t1_rsp_early", bus.rsp_valid, 0);
            if (k == 0) check("t1_add_issue_drop", bus.add_issue, 0);
        end
        tick();
        @(negedge clk);
        check("t1_rsp_valid",  bus.rsp_valid,  1);
        check("t1_rsp_result", bus.rsp_result, 32'h4040_0000);
        check("t1_rsp_id",     bus.rsp_id,     0);
        check("t1_rsp_flags",  bus.rsp_flags,  3'b000);
        tick();

        // 2: both requesters contend; alternate grants and ordered responses
        do_reset();
        gb = got_res.size();
        bus.rsp_ready = 1;
        bus.req0_valid = 1; bus.req0_a = 32'h10; bus.req0_b = 32'h1; bus.req0_sub = 0;
        bus.req1_valid = 1; bus.req1_a = 32'h20; bus.req1_b = 32'h2; bus.req1_sub = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_req0_ready", bus.req0_ready, 64'(i % 2 == 0));
            check("t2_req1_ready", bus.req1_ready, 64'(i % 2 == 1));
            tick();
            if (i == 0) bus.req0_a = 32'h30;
            if (i == 1) bus.req1_a = 32'h40;
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        e_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
        e_res = '{32'h11, 32'h1E, 32'h31, 32'h3E};
        wait_rsp(gb + 4, "t2_rsp_count");
        for (int i = 0; i < 4; i++) begin
            if (gb + i < got_res.size()) begin
                check("t2_rsp_id",     got_id[gb+i],  e_id[i]);
                check("t2_rsp_result", got_res[gb+i], e_res[i]);
            end
        end

        // 3: stalled consumer throttles admission at RSP_DEPTH outstanding
        do_reset();
        gb = got_res.size();
        ab = acc0_cnt;
        bus.rsp_ready = 0;
        bus.req0_valid = 1; bus.req0_a = 32'h100; bus.req0_b = 32'h0; bus.req0_sub = 0;
        repeat (16) tick();
        @(negedge clk);
        check("t3_accepts",   64'(acc0_cnt - ab), 8);
        check("t3_ready_off", bus.req0_ready, 0);
        check("t3_occ",       dut.occ, 8);
        check("t3_busy",      busy, 1);
        check("t3_rsp_valid", bus.rsp_valid, 1);
        tick();
        bus.rsp_ready = 1;
        @(negedge clk);
        check("t3_pop_no_credit", bus.req0_ready, 0);
        tick();
        bus.rsp_ready = 0;
        @(negedge clk);
        check("t3_credit_back", bus.req0_ready, 1);
        tick();
        @(negedge clk);
        check("t3_accepts_after", 64'(acc0_cnt - ab), 9);
        check("t3_ready_off2",    bus.req0_ready, 0);
        check("t3_occ_full",      dut.occ, 8);
        tick();
        bus.req0_valid = 0;
        bus.rsp_ready = 1;
        wait_rsp(gb + 9, "t3_drain_count");
        @(negedge clk);
        check("t3_idle", busy, 0);
        tick();

        // 4: sustained throughput, 20 back-to-back ops
        gb = got_res.size();
        ab = acc0_cnt;
        bus.rsp_ready = 1;
        bus.req0_valid = 1; bus.req0_b = 32'h1000; bus.req0_sub = 0;
        for (int i = 0; i < 20; i++) begin
            bus.req0_a = 32'(i);
            @(negedge clk);
            check("t4_no_bubble", bus.req0_ready, 1);
            tick();
        end
        bus.req0_valid = 0;
        check("t4_accepts", 64'(acc0_cnt - ab), 20);
        wait_rsp(gb + 20, "t4_rsp_count");
        for (int i = 0; i < 20; i++) begin
            if (gb + i < got_res.size()) begin
                check("t4_rsp_result", got_res[gb+i], 32'h1000 + 32'(i));
                check("t4_rsp_id",     got_id[gb+i],  0);
            end
        end

        // 5: overflow flags pass through with requester 1's id
        gb = got_res.size();
        bus.req1_valid = 1; bus.req1_a = 32'h7F00_0000; bus.req1_b = 32'h7F00_0000; bus.req1_sub = 0;
        @(negedge clk);
        check("t5_req1_ready", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 0;
        wait_rsp(gb + 1, "t5_rsp_count");
        if (gb < got_res.size()) begin
            check("t5_rsp_result", got_res[gb], 32'h7F80_0000);
            check("t5_rsp_flags",  got_flg[gb], 3'b100);
            check("t5_rsp_id",     got_id[gb],  1);
        end

        // 6: reset with work in flight and queued; nothing stale may emerge
        bus.rsp_ready = 0;
        bus.req0_valid = 1; bus.req0_b = 32'h0; bus.req0_sub = 0;
        for (int i = 0; i < 5; i++) begin
            bus.req0_a = 32'h500 + 32'(i);
            tick();
        end
        bus.req0_valid = 0;
        tick();
        tick();
        @(negedge clk);
        check("t6_pre_fifo_cnt", dut.fifo_cnt, 2);
        check("t6_pre_busy",     busy, 1);
        rst = 1'b0;
        #1;
        check("t6_rst_rsp_valid",  bus.rsp_valid,  0);
        check("t6_rst_busy",       busy,           0);
        check("t6_rst_add_issue",  bus.add_issue,  0);
        check("t6_rst_rsp_result", bus.rsp_result, 0);
        tick();
        tick();
        rst = 1'b1;
        bus.rsp_ready = 1;
        gb = got_res.size();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6_no_stale", bus.rsp_valid, 0);
            tick();
        end
        check("t6_no_stale_pops", 64'(got_res.size() - gb), 0);
        bus.req1_valid = 1; bus.req1_a = 32'h3F80_0000; bus.req1_b = 32'h4000_0000; bus.req1_sub = 0;
        tick();
        bus.req1_valid = 0;
        wait_rsp(gb + 1, "t6_new_rsp_count");
        if (gb < got_res.size()) begin
            check("t6_new_result", got_res[gb], 32'h4040_0000);
            check("t6_new_id",     got_id[gb],  1);
            check("t6_new_flags",  got_flg[gb], 3'b000);
        end
        repeat (3) tick();
        check("t6_final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_add_issue_ctrl.md
Name: fpu_add_issue_ctrl

Overview:
- Issue/return controller that shares one pipelined FP adder between two requesters.
- Round-robin arbitrates requests and launches one operation per cycle into the fixed-latency, non-stallable adder pipeline.
- Tracks in-flight operations with a tag shift register and buffers results and flags in a response FIFO.
- Uses credit-based admission so a stalled consumer can never cause a result to be dropped.

Parameters:
- LATENCY, 4, adder cycles from add_issue to add_result valid (≥1).
- RSP_DEPTH, 8, response FIFO entries and maximum outstanding operations (≥1).
- DATA_W, 32, operand/result width (IEEE-754 single).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a  in  DATA_W  operand A.
- req0_b  in  DATA_W  operand B.
- req0_sub  in  1  1 = A-B, 0 = A+B.
- req1_valid / req1_ready / req1_a / req1_b / req1_sub  same as requester 0.
- add_issue  out  1  registered launch strobe to the adder.
- add_a  out  DATA_W  registered operand A.
- add_b  out  DATA_W  registered operand B.
- add_sub  out  1  registered operation select.
- add_result  in  DATA_W  adder sum, valid LATENCY cycles after add_issue.
- add_flags  in  3  {overflow, underflow, invalid}, aligned with add_result.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer takes head.
- rsp_id  out  1  requester that issued the head operation.
- rsp_result  out  DATA_W  head result.
- rsp_flags  out  3  head flags.
- busy  out  1  occ != 0.

Behaviour:
- Reset (rst=0, async): add_issue=0, add_a/add_b/add_sub=0, tag shift register cleared, FIFO empty, occ=0, rr pointer=requester 0, rsp_valid=0, rsp_result/rsp_flags/rsp_id=0, busy=0. In-flight operations are discarded; results from the adder arriving after reset release are ignored because their tag valid bits are 0.
- occ counter (0..RSP_DEPTH):
  - +1 on accept, -1 on pop (rsp_valid & rsp_ready).
  - Simultaneous accept and pop leaves occ unchanged.
- credit_ok = (occ < RSP_DEPTH), using the registered occ only. A same-cycle pop does not create credit.
- Arbitration (combinational ready):
  - Only one valid requester: it is granted.
  - Both valid: the rr-pointer side is granted.
  - reqX_ready = grantX & credit_ok. An accept is valid & ready.
  - After each accept, rr points to the other requester. The pointer does not change with no accept.
  - reqX_ready may depend on the other requester's valid.
- Issue stage: an accept in cycle T registers the operands and sub into add_* and sets add_issue=1 in cycle T+1. With no accept, add_issue=0 and add_a/add_b/add_sub hold their values.
- Tag pipe: a LATENCY-deep shift register of {valid, id}, entered alongside add_issue. Its output marks add_result/add_flags as valid in cycle T+1+LATENCY, and they are pushed into the FIFO at the end of that cycle.
- FIFO:
  - First-word-fall-through; head drives rsp_result, rsp_flags, rsp_id.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - Order is strictly issue order.
  - Push while full is impossible by the credit rule. The bench asserts this.
- Latency: accept in cycle T → rsp_valid in cycle T+LATENCY+2 when the FIFO is empty. Flags are passed through unmodified.
- Throughput: 1 operation/cycle sustained when rsp_ready=1 and RSP_DEPTH ≥ LATENCY+3. A smaller depth throttles admission but never loses data.
- rsp_valid is held with its data stable until rsp_ready.

Test Plan:
1. Reset, LATENCY=4. req0 issues 0x3F800000+0x40000000 in cycle 10, req1 idle → req0_ready=1 in cycle 10; add_issue=1 in cycle 11; rsp_valid=1 in cycle 16 with rsp_result=0x40400000, rsp_id=0, flags=000.
2. Both requesters valid for 4 cycles from reset → accepts in order req0, req1, req0, req1; responses return in the same id order 0, 1, 0, 1.
3. rsp_ready=0, req0 continuously valid, RSP_DEPTH=8 → exactly 8 accepts, then req0_ready=0 and occ=8. rsp_ready=1 for one cycle → one pop; the next accept occurs one cycle later.
4. RSP_DEPTH=8, rsp_ready=1, req0 valid for 20 cycles → 20 consecutive accepts with no bubbles; 20 responses in order.
5. Adder model drives add_flags=100 with result 0x7F800000 → rsp_flags=100, rsp_result=0x7F800000, with the correct id.
6. Assert rst low with 3 operations in flight and 2 in the FIFO, then release → rsp_valid=0, busy=0; no stale responses appear over the next 10 cycles; a new request completes normally.
